// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: static decode plus IF/ID/EX/MEM/WB sequencer.
// Optional MEM wait handshake on mem_ready is compiled in with MULTICYCLE_MEM_WAIT_EN.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        PCWr,
    output logic        IRWr,
    output logic        RegWr,
    output logic        MemWr,
    output logic        nPC_sel,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic [1:0]  ExtOp,
    output logic [2:0]  ALUctr,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;

    logic is_add_s, is_sub_s, is_and_s, is_addi_s, is_ori_s, is_andi_s;
    logic is_lw_s, is_sw_s, is_beq_s, is_lui_s, is_rtype_s, legal_s;
    logic mem_done_s;
    logic pc_wr_s, ir_wr_s, reg_wr_s, mem_wr_s, npc_sel_s, illegal_s, retire_s;
    logic [2:0] alu_ctr_s;
    logic [1:0] ext_op_s;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_done_s = mem_ready;
`else
    logic unused_mem_ready_s;
    assign unused_mem_ready_s = mem_ready;
    assign mem_done_s         = 1'b1;
`endif

    // Instruction decode: one-hot instruction class flags from opcode/funct
    always_comb begin
        is_add_s  = 1'b0;
        is_sub_s  = 1'b0;
        is_and_s  = 1'b0;
        is_addi_s = 1'b0;
        is_ori_s  = 1'b0;
        is_andi_s = 1'b0;
        is_lw_s   = 1'b0;
        is_sw_s   = 1'b0;
        is_beq_s  = 1'b0;
        is_lui_s  = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21: is_add_s = 1'b1;
                    6'h22, 6'h23: is_sub_s = 1'b1;
                    6'h24:        is_and_s = 1'b1;
                    default:      is_add_s = 1'b0;
                endcase
            end
            6'h08, 6'h09: is_addi_s = 1'b1;
            6'h0D:        is_ori_s  = 1'b1;
            6'h0C:        is_andi_s = 1'b1;
            6'h23:        is_lw_s   = 1'b1;
            6'h2B:        is_sw_s   = 1'b1;
            6'h04:        is_beq_s  = 1'b1;
            6'h0F:        is_lui_s  = 1'b1;
            default:      is_add_s  = 1'b0;
        endcase
    end

    assign is_rtype_s = is_add_s | is_sub_s | is_and_s;
    assign legal_s    = is_rtype_s | is_addi_s | is_ori_s | is_andi_s |
                        is_lw_s | is_sw_s | is_beq_s | is_lui_s;

    // Static datapath controls; every flag is zero for an illegal encoding
    always_comb begin
        alu_ctr_s = 3'b000;
        ext_op_s  = 2'b00;
        if (is_add_s | is_addi_s | is_lw_s | is_sw_s) begin
            alu_ctr_s = 3'b010;
        end else if (is_ori_s) begin
            alu_ctr_s = 3'b001;
        end else if (is_sub_s | is_beq_s) begin
            alu_ctr_s = 3'b110;
        end else if (is_lui_s) begin
            alu_ctr_s = 3'b111;
        end else begin
            alu_ctr_s = 3'b000;
        end
        if (is_addi_s | is_lw_s | is_sw_s) begin
            ext_op_s = 2'b01;
        end else if (is_lui_s) begin
            ext_op_s = 2'b10;
        end else begin
            ext_op_s = 2'b00;
        end
    end

    assign ALUctr   = alu_ctr_s;
    assign ExtOp    = ext_op_s;
    assign RegDst   = is_rtype_s;
    assign ALUSrc   = is_ori_s | is_andi_s | is_addi_s | is_lw_s | is_sw_s | is_lui_s;
    assign MemtoReg = is_lw_s;

    // Sequencer: next state, write strobes and retirement
    always_comb begin
        state_d   = state_q;
        pc_wr_s   = 1'b0;
        ir_wr_s   = 1'b0;
        reg_wr_s  = 1'b0;
        mem_wr_s  = 1'b0;
        npc_sel_s = 1'b0;
        illegal_s = 1'b0;
        retire_s  = 1'b0;
        case (state_q)
            S_IF: begin
                ir_wr_s = 1'b1;
                pc_wr_s = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                if (legal_s) begin
                    state_d = S_EX;
                end else begin
                    illegal_s = 1'b1;
                    state_d   = S_IF;
                end
            end
            S_EX: begin
                if (is_beq_s) begin
                    npc_sel_s = 1'b1;
                    pc_wr_s   = zero;
                    retire_s  = 1'b1;
                    state_d   = S_IF;
                end else if (is_lw_s | is_sw_s) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (is_sw_s) begin
                    mem_wr_s = 1'b1;
                    if (mem_done_s) begin
                        retire_s = 1'b1;
                        state_d  = S_IF;
                    end else begin
                        state_d = S_MEM;
                    end
                end else if (is_lw_s) begin
                    state_d = mem_done_s ? S_WB : S_MEM;
                end else begin
                    state_d = S_IF;
                end
            end
            S_WB: begin
                reg_wr_s = 1'b1;
                retire_s = 1'b1;
                state_d  = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    assign retired_d = retired_q + {31'd0, retire_s};

    // Strobes are gated by reset so an aborted instruction writes nothing
    assign PCWr    = pc_wr_s   & ~reset;
    assign IRWr    = ir_wr_s   & ~reset;
    assign RegWr   = reg_wr_s  & ~reset;
    assign MemWr   = mem_wr_s  & ~reset;
    assign nPC_sel = npc_sel_s & ~reset;
    assign illegal = illegal_s & ~reset;
    assign state   = state_q;
    assign retired = retired_q;

    // State and retirement counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IF;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 (sole clock, rising edge); reset input 1 (synchronous, active-high).
REQ-002 SHALL have ports: opcode input 6, funct input 6 (from datapath IR, stable after IF); zero input 1 (ALU zero flag); mem_ready input 1 (data memory done).
REQ-003 SHALL have write-strobe outputs, each 1 bit: PCWr (PC update), IRWr (load IR), RegWr, MemWr, nPC_sel (0 = +4, 1 = branch target).
REQ-004 SHALL have static-control outputs: RegDst 1 (0 = rt, 1 = rd); ALUSrc 1 (1 = immediate operand); MemtoReg 1 (1 = memory data); ExtOp 2 (00 zero, 01 sign, 10 lui); ALUctr 3 (010 add, 110 sub, 001 or, 000 and, 111 lui).
REQ-005 SHALL have status outputs: state 3 (current FSM state); illegal 1 (one-cycle pulse); retired 32 (count of retired instructions).

Function
REQ-006 SHALL decode these instructions: add/addu (op 00, funct 20/21); sub/subu (op 00, funct 22/23); and (op 00, funct 24); addi/addiu (08/09); ori (0D); andi (0C); lw (23); sw (2B); beq (04); lui (0F). All other encodings are illegal.
REQ-007 SHALL drive static controls combinationally from opcode/funct in every state:
- ALUctr: add/addi/lw/sw -> 010; ori -> 001; sub/beq -> 110; lui -> 111; and/andi -> 000.
- ExtOp: addi/lw/sw -> 01; lui -> 10; all others -> 00.
- RegDst = R-type; ALUSrc = ori|andi|addi|lw|sw|lui; MemtoReg = lw.
- Illegal encodings drive all static controls to 0.
REQ-008 SHALL implement FSM states IF=0, ID=1, EX=2, MEM=3, WB=4; codes 5-7 SHALL go to IF on the next edge.
REQ-009 SHALL in IF assert IRWr=1, PCWr=1, nPC_sel=0, then go to ID.
REQ-010 SHALL in ID go to EX for a legal instruction; for an illegal one, pulse illegal=1 for that cycle and go to IF without retiring.
REQ-011 SHALL in EX route as follows:
- beq: assert nPC_sel=1 and PCWr=zero, retire, go to IF.
- lw/sw: go to MEM.
- all others: go to WB.
REQ-012 SHALL in MEM route as follows:
- sw: assert MemWr=1; on MEM exit, retire and go to IF.
- lw: go to WB on MEM exit.
REQ-013 SHALL in WB assert RegWr=1, retire, go to IF.
REQ-014 SHALL deassert every write strobe outside the states named in REQ-009..REQ-013.
REQ-015 SHALL take cycles per instruction (IF to next IF) as: beq 3, R/I-type ALU 4, sw 4, lw 5, illegal 2; MEM wait cycles (REQ-022) add to sw and lw.
REQ-016 SHALL increment retired by 1 on the edge ending each retiring cycle, wrapping 0xFFFFFFFF -> 0.
REQ-017 SHALL treat opcode/funct changes outside IF as don't-care.

Reset
REQ-018 SHALL force every write strobe and illegal to 0 combinationally while reset=1, regardless of state.
REQ-019 SHALL on a clock edge with reset=1 set state=IF and retired=0.
REQ-020 SHALL treat reset asserted mid-instruction as an abort: no partial retirement, and the first post-reset cycle is IF with PCWr=1.

Configuration
REQ-021 SHALL compile the MEM wait handshake in or out with macro MULTICYCLE_MEM_WAIT_EN.
REQ-022 SHALL, with MULTICYCLE_MEM_WAIT_EN defined, hold MEM while mem_ready=0, keeping MemWr=1 for sw throughout, and exit MEM on the edge where mem_ready=1.
REQ-023 SHALL, without the macro, ignore mem_ready and keep MEM for exactly one cycle.

Verification
REQ-024 SHALL verify add: op 00, funct 20 from reset release -> states 0,1,2,4,0; RegWr=1 only in WB; RegDst=1, ALUctr=010; retired 0->1.
REQ-025 SHALL verify beq: op 04 with zero=1 -> EX shows PCWr=1, nPC_sel=1, ALUctr=110, 3-cycle CPI. Repeat with zero=0 -> PCWr=0 in EX.
REQ-026 SHALL verify lw/sw: lw (23) -> 5 cycles, MemtoReg=1, ExtOp=01, RegWr only in WB; sw (2B) -> MemWr=1 for one MEM cycle, RegWr never 1.
REQ-027 SHALL verify illegal handling: op 3F -> illegal pulse in ID, back to IF next cycle, retired unchanged, no RegWr/MemWr.
REQ-028 SHALL verify reset mid-op: reset=1 during WB of ori (0D) -> RegWr=0 that cycle, state=0 and retired=0 on the next edge.
REQ-029 SHALL verify the MEM wait with MULTICYCLE_MEM_WAIT_EN: sw with mem_ready low for 3 cycles -> MemWr=1 for 4 cycles, CPI 7. Without the macro, CPI 4 regardless of mem_ready.
